tl_arbiter: RTL

- Round-robin arbiter sharing one TileLink-UL master port between NUM_MASTERS requesters (CPU fetch/data, DMA, program loader).
- Sits between the requesters and the single input of tl_switch.
- Widens source IDs so D-channel responses route back to the issuing requester.
- Enforces per-requester outstanding-transaction limits.

---
 rtl/tl_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/tl_arbiter.sv
// Round-robin TileLink-UL A-channel arbiter with source-ID widening and D-channel return routing.
// Build option: define TL_ARB_FIXED_PRIO_EN for fixed priority, where the lowest eligible index wins.
//
// state  | meaning
// IDLE   | grant follows the eligible requests combinationally
// LOCKED | A beat stalled downstream; grant held on lock_idx until handshake
module tl_arbiter #(
    parameter int NUM_MASTERS     = 2,
    parameter int XLEN            = 32,
    parameter int SID_WIDTH       = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_MASTERS-1:0]              m_a_valid,
    output logic [NUM_MASTERS-1:0]              m_a_ready,
    input  logic [NUM_MASTERS*3-1:0]            m_a_opcode,
    input  logic [NUM_MASTERS*3-1:0]            m_a_param,
    input  logic [NUM_MASTERS*3-1:0]            m_a_size,
    input  logic [NUM_MASTERS*SID_WIDTH-1:0]    m_a_source,
    input  logic [NUM_MASTERS*XLEN-1:0]         m_a_address,
    input  logic [NUM_MASTERS*(XLEN/8)-1:0]     m_a_mask,
    input  logic [NUM_MASTERS*XLEN-1:0]         m_a_data,
    output logic [NUM_MASTERS-1:0]              m_d_valid,
    input  logic [NUM_MASTERS-1:0]              m_d_ready,
    output logic [2:0]                          m_d_opcode,
    output logic [1:0]                          m_d_param,
    output logic [2:0]                          m_d_size,
    output logic [SID_WIDTH-1:0]                m_d_source,
    output logic [XLEN-1:0]                     m_d_data,
    output logic                                m_d_corrupt,
    output logic                                m_d_denied,
    output logic                                s_a_valid,
    input  logic                                s_a_ready,
    output logic [2:0]                          s_a_opcode,
    output logic [2:0]                          s_a_param,
    output logic [2:0]                          s_a_size,
    output logic [SID_WIDTH+$clog2(NUM_MASTERS)-1:0] s_a_source,
    output logic [XLEN-1:0]                     s_a_address,
    output logic [XLEN/8-1:0]                   s_a_mask,
    output logic [XLEN-1:0]                     s_a_data,
    input  logic                                s_d_valid,
    output logic                                s_d_ready,
    input  logic [2:0]                          s_d_opcode,
    input  logic [1:0]                          s_d_param,
    input  logic [2:0]                          s_d_size,
    input  logic [SID_WIDTH+$clog2(NUM_MASTERS)-1:0] s_d_source,
    input  logic [XLEN-1:0]                     s_d_data,
    input  logic                                s_d_corrupt,
    input  logic                                s_d_denied
);
    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam int MW    = XLEN / 8;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t               state;
    logic [IDX_W-1:0]     lock_idx;
    logic [IDX_W-1:0]     grant;
    logic [IDX_W-1:0]     d_idx;
    logic                 d_in_range;
    logic                 any_elig;
    logic                 a_hs;
    logic                 d_hs;
    logic [NUM_MASTERS-1:0] eligible;
    logic [NUM_MASTERS-1:0] cnt_inc;
    logic [NUM_MASTERS-1:0] cnt_dec;
    logic [3:0]           out_cnt [NUM_MASTERS];
`ifndef TL_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]     rr_ptr;
`endif

    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            eligible[i] = m_a_valid[i] && (out_cnt[i] < 4'(MAX_OUTSTANDING));
        end
    end

    // Scan downwards so the last hit is the highest-priority candidate.
    always_comb begin
        int cand;
        cand     = 0;
        grant    = '0;
        any_elig = 1'b0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
`ifdef TL_ARB_FIXED_PRIO_EN
            cand = k;
`else
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
`endif
            if (eligible[cand[IDX_W-1:0]]) begin
                grant    = cand[IDX_W-1:0];
                any_elig = 1'b1;
            end
        end
        if (state == LOCKED) grant = lock_idx;
    end

    assign s_a_valid   = !reset && ((state == LOCKED) || any_elig);
    assign a_hs        = s_a_valid && s_a_ready;
    assign s_a_opcode  = m_a_opcode[3*grant +: 3];
    assign s_a_param   = m_a_param[3*grant +: 3];
    assign s_a_size    = m_a_size[3*grant +: 3];
    assign s_a_source  = {grant, m_a_source[SID_WIDTH*grant +: SID_WIDTH]};
    assign s_a_address = m_a_address[XLEN*grant +: XLEN];
    assign s_a_mask    = m_a_mask[MW*grant +: MW];
    assign s_a_data    = m_a_data[XLEN*grant +: XLEN];

    assign d_idx       = s_d_source[SID_WIDTH+IDX_W-1:SID_WIDTH];
    assign d_in_range  = int'(d_idx) < NUM_MASTERS;
    assign m_d_opcode  = s_d_opcode;
    assign m_d_param   = s_d_param;
    assign m_d_size    = s_d_size;
    assign m_d_source  = s_d_source[SID_WIDTH-1:0];
    assign m_d_data    = s_d_data;
    assign m_d_corrupt = s_d_corrupt;
    assign m_d_denied  = s_d_denied;

    // Beats for a non-existent requester are accepted and discarded.
    always_comb begin
        m_d_valid = '0;
        s_d_ready = 1'b0;
        if (!reset) begin
            if (d_in_range) begin
                m_d_valid[d_idx] = s_d_valid;
                s_d_ready        = m_d_ready[d_idx];
            end else begin
                s_d_ready = 1'b1;
            end
        end
    end

    assign d_hs = s_d_valid && s_d_ready && d_in_range;

    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            m_a_ready[i] = a_hs && (grant == IDX_W'(i));
            cnt_inc[i]   = a_hs && (grant == IDX_W'(i));
            cnt_dec[i]   = d_hs && (d_idx == IDX_W'(i)) && (out_cnt[i] != 4'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            lock_idx <= '0;
`ifndef TL_ARB_FIXED_PRIO_EN
            rr_ptr   <= '0;
`endif
            for (int i = 0; i < NUM_MASTERS; i++) out_cnt[i] <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_a_valid && !s_a_ready) begin
                        state    <= LOCKED;
                        lock_idx <= grant;
                    end
                end
                LOCKED: begin
                    if (s_a_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
`ifndef TL_ARB_FIXED_PRIO_EN
            if (a_hs) begin
                rr_ptr <= (int'(grant) == NUM_MASTERS - 1) ? '0 : grant + 1'b1;
            end
`endif
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (cnt_inc[i] && !cnt_dec[i]) out_cnt[i] <= out_cnt[i] + 4'd1;
                else if (cnt_dec[i] && !cnt_inc[i]) out_cnt[i] <= out_cnt[i] - 4'd1;
            end
        end
    end

endmodule
